// File: rtl/div_seq_ctrl.sv
// Multi-cycle restoring divider sequencer for DIV/DIVU in the execute stage.
// Produces {remainder, quotient} one quotient bit per cycle, with stall and annul handling.
module div_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 stallreq_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   dvd_q;
    logic [WIDTH-1:0]   dvs_q;
    logic               neg_a_q;
    logic               neg_b_q;

    // Two's-complement negate when en is set; the most negative value maps onto itself.
    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
        logic signed [WIDTH-1:0] s;
        s = signed'(v);
        return en ? WIDTH'(-s) : v;
    endfunction

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               borrow;
    logic [WIDTH-1:0]   quot_fin;
    logic [WIDTH-1:0]   rem_fin;

    always_comb begin
        a_neg    = signed_div_i & opdata1_i[WIDTH-1];
        b_neg    = signed_div_i & opdata2_i[WIDTH-1];
        abs_a    = neg_if(opdata1_i, a_neg);
        abs_b    = neg_if(opdata2_i, b_neg);
        // Partial remainder is always below the divisor, so a WIDTH+1 bit difference
        // exposes the borrow in its top bit.
        shifted  = {rem_q, dvd_q[WIDTH-1]};
        diff     = shifted - {1'b0, dvs_q};
        borrow   = diff[WIDTH];
        quot_fin = neg_if(dvd_q, neg_a_q ^ neg_b_q);
        rem_fin  = neg_if(rem_q, neg_a_q);
    end

    assign stallreq_o = start_i & ~ready_o & ~annul_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_FREE;
            cnt      <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                S_FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state <= S_BYZERO;
                        end else begin
                            state   <= S_ON;
                            cnt     <= '0;
                            rem_q   <= '0;
                            dvd_q   <= abs_a;
                            dvs_q   <= abs_b;
                            neg_a_q <= a_neg;
                            neg_b_q <= b_neg;
                        end
                    end
                end
                S_BYZERO: begin
                    if (annul_i) begin
                        state <= S_FREE;
                    end else begin
                        state    <= S_END;
                        result_o <= '0;
                        ready_o  <= 1'b1;
                    end
                end
                S_ON: begin
                    if (annul_i) begin
                        state    <= S_FREE;
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state    <= S_END;
                        result_o <= {rem_fin, quot_fin};
                        ready_o  <= 1'b1;
                    end else begin
                        // Dividend register doubles as the quotient shift register.
                        rem_q <= borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                        dvd_q <= {dvd_q[WIDTH-2:0], ~borrow};
                        cnt   <= cnt + CNT_W'(1);
                    end
                end
                S_END: begin
                    if (!start_i) begin
                        state    <= S_FREE;
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_FREE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: unsigned/signed divides, divide-by-zero,
// annul, asynchronous reset and result hold while start stays high.
module tb_div_seq_ctrl;

    localparam int WIDTH = 32;

    logic               clk;
    logic               rst;
    logic               start_i;
    logic               annul_i;
    logic               signed_div_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
    logic               stallreq_o;

    int n_tests = 0;
    int n_fail  = 0;

    div_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raises start with the given operands and checks ready timing and result.
    // Leaves start high on return so the caller can exercise the END state.
    task automatic run_div(input string tag, input logic sg, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic [63:0] exp, input bit byz);
        int  lat;
        bit  early;
        signed_div_i = sg;
        opdata1_i    = a;
        opdata2_i    = b;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        #1;
        chk_eq({tag, "_stall_first"}, 64'(stallreq_o), 64'd1);
        step();
        // Scramble operands after sampling; only latched values may matter.
        opdata1_i = ~a;
        opdata2_i = b + 32'd3;
        lat   = byz ? 1 : WIDTH + 1;
        early = 1'b0;
        for (int i = 0; i < lat; i++) begin
            if (ready_o !== 1'b0 || stallreq_o !== 1'b1) early = 1'b1;
            step();
        end
        chk_eq({tag, "_busy_window"}, 64'(early), 64'd0);
        chk_eq({tag, "_ready"}, 64'(ready_o), 64'd1);
        chk_eq({tag, "_result"}, result_o, exp);
        chk_eq({tag, "_stall_ready"}, 64'(stallreq_o), 64'd0);
    endtask

    task automatic drop_start(input string tag);
        start_i = 1'b0;
        step();
        chk_eq({tag, "_drop_ready"}, 64'(ready_o), 64'd0);
        chk_eq({tag, "_drop_result"}, result_o, 64'd0);
    endtask

    initial begin
        bit seen;
        logic [63:0] held;
        rst          = 1'b1;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        #3 rst = 1'b0;
        step();
        step();
        chk_eq("rst_result", result_o, 64'd0);
        chk_eq("rst_ready", 64'(ready_o), 64'd0);
        chk_eq("rst_stall", 64'(stallreq_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Unsigned 100/7 = 14 r 2
        run_div("u100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);
        drop_start("u100_7");

        // Signed cases
        run_div("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
        drop_start("s-7_2");
        run_div("s7_-2", 1'b1, 32'h7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 1'b0);
        drop_start("s7_-2");
        run_div("smin_-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 1'b0);
        drop_start("smin_-1");
        // Same operands unsigned: 0x80000000 / 0xFFFFFFFF = 0 r 0x80000000
        run_div("umin_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0}, 1'b0);
        drop_start("umin_max");

        // Divide by zero
        run_div("byz", 1'b0, 32'd123, 32'd0, 64'd0, 1'b1);
        drop_start("byz");

        // Annul at iteration 10 of 100/7
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        step();
        for (int i = 0; i < 10; i++) step();
        annul_i = 1'b1;
        #1;
        chk_eq("annul_stall", 64'(stallreq_o), 64'd0);
        step();
        start_i = 1'b0;
        annul_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ready_o !== 1'b0) seen = 1'b1;
            step();
        end
        chk_eq("annul_no_ready", 64'(seen), 64'd0);
        run_div("u50_5", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 1'b0);

        // Asynchronous reset while holding a completed result
        #2 rst = 1'b0;
        #1;
        chk_eq("rst_end_result", result_o, 64'd0);
        chk_eq("rst_end_ready", 64'(ready_o), 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();

        // Asynchronous reset mid-iteration
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        step();
        for (int i = 0; i < 5; i++) step();
        #2 rst = 1'b0;
        #1;
        chk_eq("rst_on_result", result_o, 64'd0);
        chk_eq("rst_on_ready", 64'(ready_o), 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ready_o !== 1'b0) seen = 1'b1;
        end
        chk_eq("rst_on_no_ready", 64'(seen), 64'd0);
        run_div("umax_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF}, 1'b0);
        drop_start("umax_1");

        // Hold in END while operands and annul wiggle
        run_div("hold", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);
        held = {32'd2, 32'd14};
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            opdata1_i = $urandom;
            opdata2_i = $urandom;
            annul_i   = (i == 2);
            step();
            if (ready_o !== 1'b1 || result_o !== held) seen = 1'b1;
        end
        annul_i = 1'b0;
        chk_eq("hold_stable", 64'(seen), 64'd0);
        drop_start("hold");
        run_div("b2b_50_5", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 1'b0);
        drop_start("b2b_50_5");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
